// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder.
//   mem_size_t     : access size encoding (BYTE=0, HALF=1, WORD=2, 3 illegal)
//   MEM_WORD_BYTES : bytes per array word
//   access_error   : alignment / size / range check for one request
//   store_byte_en  : byte-lane write enables for a store
//   store_lanes    : store data replicated onto every lane it may land in
//   load_extend    : lane select plus sign/zero extension for loads
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } mem_size_t;

    localparam int MEM_WORD_BYTES = 4;

    // Misaligned half/word, illegal size, or word index beyond the array.
    function automatic logic access_error(input mem_size_t size, input logic [1:0] lo,
                                          input logic in_range);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = lo[0];
            SIZE_WORD: err = (lo != 2'b00);
            default:   err = 1'b1;
        endcase
        return err | ~in_range;
    endfunction

    function automatic logic [3:0] store_byte_en(input mem_size_t size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the low bytes means the byte enables alone pick the lane.
    function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{wdata[7:0]}};
            SIZE_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Little-endian lane select: byte lane is lo, half lane is lo[1].
    function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_t size,
                                                input logic [1:0] lo, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            SIZE_WORD: r = word;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_push, i_data     : write an entry (accepted when not full, or when popping at full)
//   i_pop              : drop the head entry (ignored when empty)
//   o_data             : head entry, zero while empty
//   o_full, o_empty    : status flags
//   o_count            : number of entries held
module rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // At full, a simultaneous pop frees the slot being written this edge.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store unit's CPU memory port.
// Accepts one load or store per cycle, performs it against a word array at the
// accept edge, and returns in-order tagged responses after LATENCY cycles via a
// response FIFO. A credit counter bounds outstanding requests to RSP_DEPTH.
//   clk, reset                : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_tag : request payload
//   rsp_valid/rsp_ready       : response handshake
//   rsp_tag, rsp_rdata, rsp_is_store, rsp_error : response payload (FIFO head)
// The array has no reset and no preload; its contents come only from stores.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_is_store,
    output logic                  rsp_error
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [LATENCY-1:0]    r_pipe_vld;
    logic [ENTRY_W-1:0]    r_pipe_ent [LATENCY];
    logic [CNT_W-1:0]      r_outstanding;
    logic                  r_req_ready;

    logic                  w_accept;
    logic                  w_rsp_pop;
    mem_size_t             w_size;
    logic [1:0]            w_lo;
    logic [ADDR_WIDTH-3:0] w_word_idx;
    logic                  w_in_range;
    logic                  w_error;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wlane;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [ENTRY_W-1:0]    w_new_entry;
    logic [CNT_W-1:0]      w_out_nxt;
    logic [ENTRY_W-1:0]    w_fifo_head;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_unused_fifo_stat;

    assign w_accept   = req_valid & r_req_ready;
    assign w_rsp_pop  = ~w_fifo_empty & rsp_ready;
    assign w_size     = mem_size_t'(req_size);
    assign w_lo       = req_addr[1:0];
    assign w_word_idx = req_addr[ADDR_WIDTH-1:2];
    assign w_in_range = (w_word_idx < (ADDR_WIDTH - 2)'(MEM_WORDS));
    assign w_error    = access_error(w_size, w_lo, w_in_range);
    assign w_be       = store_byte_en(w_size, w_lo);
    assign w_wlane    = store_lanes(w_size, req_wdata);
    // Read of the pre-edge contents; a store in an earlier cycle is already visible.
    assign w_rd_word  = r_mem[w_word_idx[IDX_W-1:0]];
    assign w_ld_data  = (req_is_store || w_error) ? '0
                        : load_extend(w_rd_word, w_size, w_lo, req_unsigned);
    assign w_new_entry = {req_tag, w_ld_data, req_is_store, w_error};

    // Data array: an accepted, error-free store updates its byte lanes.
    always_ff @(posedge clk) begin
        if (w_accept && req_is_store && !w_error) begin
            for (int i = 0; i < MEM_WORD_BYTES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx[IDX_W-1:0]][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    // Fixed-latency shift register; never stalls because credits reserve FIFO room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_ent[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_ent[0] <= w_new_entry;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_ent[i] <= r_pipe_ent[i-1];
            end
        end
    end

    // Next credit count: +1 on accept, -1 on response handshake.
    always_comb begin
        w_out_nxt = r_outstanding;
        case ({w_accept, w_rsp_pop})
            2'b10:   w_out_nxt = r_outstanding + CNT_W'(1);
            2'b01:   w_out_nxt = r_outstanding - CNT_W'(1);
            default: w_out_nxt = r_outstanding;
        endcase
    end

    // Credit counter and registered ready; ready stays low during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
            r_req_ready   <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_req_ready   <= (w_out_nxt < CNT_W'(RSP_DEPTH));
        end
    end

    rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (r_pipe_vld[LATENCY-1]),
        .i_data  (r_pipe_ent[LATENCY-1]),
        .i_pop   (w_rsp_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Credits already bound occupancy, so FIFO status is informational only.
    assign w_unused_fifo_stat = {w_fifo_full, w_fifo_count};

    assign req_ready = r_req_ready;
    assign rsp_valid = ~w_fifo_empty;
    assign {rsp_tag, rsp_rdata, rsp_is_store, rsp_error} = w_fifo_head;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_ready, rsp_is_store, rsp_error;
    logic [4:0]  rsp_tag;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] rdata;
        logic        is_store;
        logic        error;
        int          cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    logic [7:0]  mb [MEM_WORDS*4];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    bit          rand_ready = 1'b0;

    data_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(5),
        .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_rdata(rsp_rdata), .rsp_is_store(rsp_is_store), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: byte-addressed memory, little-endian, applied at accept.
    task automatic model_accept();
        rsp_t        e;
        int          n;
        logic [31:0] v;
        n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        e.tag = req_tag; e.is_store = req_is_store; e.rdata = 32'd0; e.cyc = cyc_n;
        e.error = (req_size == 2'd3) || (req_addr % n != 0) || (req_addr / 4 >= MEM_WORDS);
        if (!e.error) begin
            if (req_is_store) begin
                for (int i = 0; i < n; i++) mb[req_addr + i] = req_wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[req_addr + i]) << (8*i));
                if (!req_unsigned && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                e.rdata = v;
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock: record accepts and response handshakes, then advance to #1 after the edge.
    task automatic step();
        rsp_t r;
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        if (req_valid && req_ready) model_accept();
        if (rsp_valid && rsp_ready) begin
            r.tag = rsp_tag; r.rdata = rsp_rdata; r.is_store = rsp_is_store;
            r.error = rsp_error; r.cyc = cyc_n;
            got_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] tag);
        int k;
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_tag = tag;
        k = 0;
        while (!req_ready && k < 200) begin
            step();
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL send_accept: req_ready=%0b after %0d cycles, required 1", req_ready, k);
        end
        step();
    endtask

    task automatic drain(input int budget);
        int k;
        req_valid = 1'b0;
        k = 0;
        while (got_q.size() < exp_q.size() && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (got_q.size() < exp_q.size()) begin
            errors++;
            $display("FAIL drain: got %0d responses, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_tag = 5'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%0b rsp_valid=%0b, required 0 0", req_ready, rsp_valid);
        end
        checks++;
        if ({rsp_tag, rsp_rdata, rsp_is_store, rsp_error} !== 39'd0) begin
            errors++;
            $display("FAIL reset_payload: tag=%0d rdata=%h st=%0b err=%0b, required all 0",
                     rsp_tag, rsp_rdata, rsp_is_store, rsp_error);
        end
        reset = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: req_ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_sw_lw();
        rsp_t want[$];
        exp_q.delete(); got_q.delete();
        send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd4);
        drain(50);
        want.push_back('{tag: 5'd3, rdata: 32'h0, is_store: 1'b1, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd4, rdata: 32'hDEAD_BEEF, is_store: 1'b0, error: 1'b0, cyc: 0});
        checks++;
        if (got_q.size() != want.size()) begin
            errors++;
            $display("FAIL sw_lw_count: got %0d, required %0d", got_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== want[i].tag || got_q[i].rdata !== want[i].rdata ||
                got_q[i].is_store !== want[i].is_store || got_q[i].error !== want[i].error) begin
                errors++;
                $display("FAIL sw_lw[%0d]: tag=%0d rdata=%h st=%0b err=%0b, required tag=%0d rdata=%h st=%0b err=%0b",
                         i, got_q[i].tag, got_q[i].rdata, got_q[i].is_store, got_q[i].error,
                         want[i].tag, want[i].rdata, want[i].is_store, want[i].error);
            end
            // rsp_valid first seen in the period after the edge LATENCY edges past the accept edge.
            checks++;
            if (got_q[i].cyc - 1 - exp_q[i].cyc != LATENCY) begin
                errors++;
                $display("FAIL sw_lw_latency[%0d]: %0d cycles, required %0d",
                         i, got_q[i].cyc - 1 - exp_q[i].cyc, LATENCY);
            end
        end
    endtask

    task automatic test_lanes();
        rsp_t want[$];
        exp_q.delete(); got_q.delete();
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F0_7F81, 5'd1);
        send(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 5'd2);
        send(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 5'd3);
        send(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd4);
        send(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5'd5);
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 5'd6);
        send(1'b1, 2'd0, 1'b0, 32'h21, {24'($urandom), 8'hAA}, 5'd7);
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd8);
        drain(50);
        want.push_back('{tag: 5'd1, rdata: 32'h0,         is_store: 1'b1, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd2, rdata: 32'hFFFF_FF81, is_store: 1'b0, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd3, rdata: 32'h0000_0081, is_store: 1'b0, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd4, rdata: 32'hFFFF_80F0, is_store: 1'b0, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd5, rdata: 32'h0000_80F0, is_store: 1'b0, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd6, rdata: 32'h0,         is_store: 1'b1, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd7, rdata: 32'h0,         is_store: 1'b1, error: 1'b0, cyc: 0});
        want.push_back('{tag: 5'd8, rdata: 32'h1122_AA44, is_store: 1'b0, error: 1'b0, cyc: 0});
        checks++;
        if (got_q.size() != want.size()) begin
            errors++;
            $display("FAIL lanes_count: got %0d, required %0d", got_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== want[i].tag || got_q[i].rdata !== want[i].rdata ||
                got_q[i].is_store !== want[i].is_store || got_q[i].error !== want[i].error) begin
                errors++;
                $display("FAIL lanes[%0d]: tag=%0d rdata=%h st=%0b err=%0b, required tag=%0d rdata=%h st=%0b err=%0b",
                         i, got_q[i].tag, got_q[i].rdata, got_q[i].is_store, got_q[i].error,
                         want[i].tag, want[i].rdata, want[i].is_store, want[i].error);
            end
        end
    endtask

    task automatic test_errors();
        rsp_t want[$];
        exp_q.delete(); got_q.delete();
        send(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 5'd11);
        send(1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_BEEF, 5'd12);
        send(1'b0, 2'd2, 1'b0, MEM_WORDS * 4, 32'h0, 5'd13);
        send(1'b1, 2'd2, 1'b0, MEM_WORDS * 4 + 32'h20, 32'h0, 5'd14);
        send(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 5'd15);
        send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd16);
        drain(50);
        want.push_back('{tag: 5'd11, rdata: 32'h0, is_store: 1'b0, error: 1'b1, cyc: 0});
        want.push_back('{tag: 5'd12, rdata: 32'h0, is_store: 1'b1, error: 1'b1, cyc: 0});
        want.push_back('{tag: 5'd13, rdata: 32'h0, is_store: 1'b0, error: 1'b1, cyc: 0});
        want.push_back('{tag: 5'd14, rdata: 32'h0, is_store: 1'b1, error: 1'b1, cyc: 0});
        want.push_back('{tag: 5'd15, rdata: 32'h0, is_store: 1'b0, error: 1'b1, cyc: 0});
        want.push_back('{tag: 5'd16, rdata: 32'h1122_AA44, is_store: 1'b0, error: 1'b0, cyc: 0});
        checks++;
        if (got_q.size() != want.size()) begin
            errors++;
            $display("FAIL errors_count: got %0d, required %0d", got_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== want[i].tag || got_q[i].rdata !== want[i].rdata ||
                got_q[i].is_store !== want[i].is_store || got_q[i].error !== want[i].error) begin
                errors++;
                $display("FAIL errors[%0d]: tag=%0d rdata=%h st=%0b err=%0b, required tag=%0d rdata=%h st=%0b err=%0b",
                         i, got_q[i].tag, got_q[i].rdata, got_q[i].is_store, got_q[i].error,
                         want[i].tag, want[i].rdata, want[i].is_store, want[i].error);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wv [6];
        int          n_acc;
        int          sz;
        int          c;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 6; i++) begin
            wv[i] = $urandom;
            send(1'b1, 2'd2, 1'b0, 32'h40 + 4*i, wv[i], 5'(i));
        end
        drain(50);
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
            req_addr = 32'h40 + 4*n_acc; req_tag = 5'(10 + n_acc);
            sz = exp_q.size();
            step();
            if (exp_q.size() > sz) n_acc++;
        end
        checks++;
        if (n_acc != RSP_DEPTH || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: accepted=%0d req_ready=%0b, required %0d and 0", n_acc, req_ready, RSP_DEPTH);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 5'd10 || rsp_rdata !== wv[0]) begin
                errors++;
                $display("FAIL bp_hold: valid=%0b tag=%0d rdata=%h, required 1 10 %h",
                         rsp_valid, rsp_tag, rsp_rdata, wv[0]);
            end
            step();
        end
        rsp_ready = 1'b1;
        c = 0;
        while (n_acc < 6 && c < 50) begin
            req_valid = 1'b1; req_addr = 32'h40 + 4*n_acc; req_tag = 5'(10 + n_acc);
            sz = exp_q.size();
            step();
            if (exp_q.size() > sz) n_acc++;
            c++;
        end
        drain(50);
        checks++;
        if (got_q.size() != 6 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: responses=%0d req_ready=%0b, required 6 and 1", got_q.size(), req_ready);
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== 5'(10 + i) || got_q[i].rdata !== wv[i] || got_q[i].error !== 1'b0) begin
                errors++;
                $display("FAIL bp_order[%0d]: tag=%0d rdata=%h err=%0b, required tag=%0d rdata=%h err=0",
                         i, got_q[i].tag, got_q[i].rdata, got_q[i].error, 10 + i, wv[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        exp_q.delete(); got_q.delete();
        send(1'b1, 2'd2, 1'b0, 32'h80, 32'h5A5A_1234, 5'd7);
        drain(50);
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 5'(20 + i));
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: rsp_valid=%0b, required 1", rsp_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_async: rsp_valid=%0b req_ready=%0b, required 0 0", rsp_valid, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (got_q.size() != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_stale: responses=%0d req_ready=%0b, required 0 and 1", got_q.size(), req_ready);
        end
        got_q.delete();
        send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 5'd9);
        drain(50);
        checks++;
        if (got_q.size() != 1 || got_q[0].tag !== 5'd9 || got_q[0].rdata !== 32'h5A5A_1234) begin
            errors++;
            $display("FAIL midop_persist: responses=%0d tag=%0d rdata=%h, required 1 9 5a5a1234",
                     got_q.size(), got_q.size() > 0 ? got_q[0].tag : 5'd0,
                     got_q.size() > 0 ? got_q[0].rdata : 32'd0);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        exp_q.delete(); got_q.delete();
        for (int w = 0; w < 64; w++) send(1'b1, 2'd2, 1'b0, 4*w, $urandom, 5'(w));
        rand_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            addr = ($urandom_range(0, 7) == 0) ? 32'(MEM_WORDS * 4 + $urandom_range(0, 255))
                                               : 32'($urandom_range(0, 255));
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 addr, $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                step();
            end
        end
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        drain(2000);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== exp_q[i].tag || got_q[i].rdata !== exp_q[i].rdata ||
                got_q[i].is_store !== exp_q[i].is_store || got_q[i].error !== exp_q[i].error) begin
                errors++;
                $display("FAIL rand[%0d]: tag=%0d rdata=%h st=%0b err=%0b, required tag=%0d rdata=%h st=%0b err=%0b",
                         i, got_q[i].tag, got_q[i].rdata, got_q[i].is_store, got_q[i].error,
                         exp_q[i].tag, exp_q[i].rdata, exp_q[i].is_store, exp_q[i].error);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
